hex_marquee: RTL and testbench

Parametrised scrolling-text driver for a bank of active-low seven-segment displays. A fixed message of glyph codes rotates across `NUM_DIGITS` displays at a prescaled rate, with pause, direction, four speeds and a manual single-step button. It sits between board switches/keys and the `HEX*` pins, and replaces fixed switch-selected rotation patterns with free-running, clocked scrolling.

---
 rtl/marquee_pkg.sv | 20 ++
 rtl/seg7_glyph.sv | 19 +
 rtl/hex_marquee.sv | 101 ++++++++++
 tb/tb_hex_marquee.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/marquee_pkg.sv
// Shared widths, glyph codes and seven-segment patterns for the scrolling
// marquee. Segment patterns are active-low, bit6 = g ... bit0 = a.
package marquee_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned GLYPH_W = 5;

    localparam logic [GLYPH_W-1:0] G_BLANK = 5'h10;
    localparam logic [GLYPH_W-1:0] G_DASH  = 5'h11;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

    // Hex digits 0..F, indexed by glyph code
    localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_glyph.sv
// Combinational glyph decoder: 5-bit glyph code to active-low segment pattern.
module seg7_glyph
    import marquee_pkg::*;
(
    input  logic [GLYPH_W-1:0] code,
    output logic [SEG_W-1:0]   seg_c
);

    // Codes 0x12..0x1F share the blank pattern with G_BLANK
    always_comb begin
        seg_c = SEG_BLANK;
        if (code[GLYPH_W-1] == 1'b0) begin
            seg_c = SEG_HEX[code[3:0]];
        end else if (code == G_DASH) begin
            seg_c = SEG_DASH;
        end
    end

endmodule

// File: rtl/hex_marquee.sv
// Scrolling-text driver: rotates a fixed glyph message across NUM_DIGITS
// active-low seven-segment displays, with pause, direction, speed and step.
module hex_marquee
    import marquee_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned MSG_LEN    = 8,
    parameter logic [GLYPH_W*MSG_LEN-1:0] MSG =
        {5'h10, 5'h10, 5'h10, 5'h10, 5'h01, 5'h0E, 5'h0D, 5'h00},
    parameter int unsigned TICK_DIV   = 12_500_000,
    localparam int unsigned POS_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
)
(
    input  logic                        CLOCK_50,
    input  logic                        RESET_N,
    input  logic [3:0]                  SW,
    input  logic                        STEP_N,
    output logic [SEG_W*NUM_DIGITS-1:0] HEX,
    output logic [POS_W-1:0]            POS
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SEL_W = $clog2(GLYPH_W * MSG_LEN);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(MSG_LEN - 1);

    logic                        step_sync1;
    logic                        step_sync2;
    logic                        step_prev;
    logic [CNT_W-1:0]            cnt;
    logic [CNT_W-1:0]            cnt_next;
    logic [POS_W-1:0]            pos;
    logic [POS_W-1:0]            pos_next;
    logic [SEG_W*NUM_DIGITS-1:0] hex_q;
    logic [SEG_W*NUM_DIGITS-1:0] hex_next;
    logic [31:0]                 limit;
    logic                        run;
    logic                        tick_c;
    logic                        step_c;
    logic                        advance_c;

    assign run    = SW[0];
    assign limit  = (TICK_DIV >> SW[3:2]) - 32'd1;
    // >= so a mid-count speed-up never overruns the new limit
    assign tick_c = run & (32'(cnt) >= limit);
    assign step_c = step_prev & ~step_sync2;
    assign advance_c = tick_c | (step_c & ~run);

    // Prescaler and position next-state
    always_comb begin
        cnt_next = cnt;
        pos_next = pos;
        if (run) begin
            cnt_next = tick_c ? '0 : cnt + CNT_W'(1);
        end
        if (advance_c) begin
            if (SW[1] == 1'b0) begin
                pos_next = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
            end else begin
                pos_next = (pos == '0) ? POS_LAST : pos - POS_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            step_sync1 <= 1'b1;
            step_sync2 <= 1'b1;
            step_prev  <= 1'b1;
            cnt        <= '0;
            pos        <= '0;
            hex_q      <= '1;
        end else begin
            step_sync1 <= STEP_N;
            step_sync2 <= step_sync1;
            step_prev  <= step_sync2;
            cnt        <= cnt_next;
            pos        <= pos_next;
            hex_q      <= hex_next;
        end
    end

    // Digit k shows glyph (pos + NUM_DIGITS-1-k) mod MSG_LEN; k=0 is rightmost
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        localparam int unsigned OFF = NUM_DIGITS - 1 - k;
        logic [SEL_W-1:0] sel;
        logic [SEG_W-1:0] seg;

        assign sel = SEL_W'(GLYPH_W * ((32'(pos) + OFF) % MSG_LEN));

        seg7_glyph u_glyph (
            .code  (MSG[sel +: GLYPH_W]),
            .seg_c (seg)
        );

        assign hex_next[SEG_W*k +: SEG_W] = seg;
    end

    assign HEX = hex_q;
    assign POS = pos;

endmodule

// File: tb/tb_hex_marquee.sv
// Directed bench for hex_marquee: reset display, wrap, right scroll, speed,
// pause/step, mid-run reset, and a full glyph table sweep on a second instance.
module tb_hex_marquee;

    function automatic logic [159:0] all_codes();
        logic [159:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[5*i +: 5] = 5'(i);
        return r;
    endfunction

    localparam logic [159:0] ALL_MSG = all_codes();

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  sw = 4'b0000;
    logic        step_n = 1'b1;
    logic [27:0] hex;
    logic [2:0]  pos;
    logic [27:0] hex_all;
    logic [4:0]  pos_all;

    int tests  = 0;
    int failed = 0;

    logic [27:0] win_tab [8];
    logic [6:0]  seg_tab [32];

    always #5 clk = ~clk;

    hex_marquee #(.NUM_DIGITS(4), .MSG_LEN(8), .TICK_DIV(8)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .SW       (sw),
        .STEP_N   (step_n),
        .HEX      (hex),
        .POS      (pos)
    );

    hex_marquee #(.NUM_DIGITS(4), .MSG_LEN(32), .MSG(ALL_MSG), .TICK_DIV(1)) dut_all (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .SW       (4'b0001),
        .STEP_N   (1'b1),
        .HEX      (hex_all),
        .POS      (pos_all)
    );

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] sw_v);
        rst_n  = 1'b0;
        sw     = sw_v;
        step_n = 1'b1;
        cycles(2);
        rst_n  = 1'b1;
    endtask

    // s=1 with TICK_DIV=8 gives a 4-cycle step period
    task automatic test_reset;
        do_reset(4'b0101);
        tests++; if (hex !== 28'hFFFFFFF) begin failed++; $display("FAIL reset_hex: got %h want %h", hex, 28'hFFFFFFF); end
        tests++; if (pos !== 3'd0) begin failed++; $display("FAIL reset_pos: got %0d want 0", pos); end
        cycles(1);
        tests++; if (hex !== win_tab[0]) begin failed++; $display("FAIL first_window: got %h want %h", hex, win_tab[0]); end
        tests++; if (pos !== 3'd0) begin failed++; $display("FAIL first_pos: got %0d want 0", pos); end
        cycles(3);
        tests++; if (pos !== 3'd1) begin failed++; $display("FAIL first_advance_pos: got %0d want 1", pos); end
        tests++; if (hex !== win_tab[0]) begin failed++; $display("FAIL hex_lag: got %h want %h", hex, win_tab[0]); end
        cycles(1);
        tests++; if (hex !== win_tab[1]) begin failed++; $display("FAIL second_window: got %h want %h", hex, win_tab[1]); end
    endtask

    task automatic test_wrap;
        do_reset(4'b0101);
        for (int k = 1; k <= 8; k++) begin
            cycles(4);
            tests++; if (pos !== 3'(k % 8)) begin failed++; $display("FAIL wrap_pos[%0d]: got %0d want %0d", k, pos, k % 8); end
            tests++; if (hex !== win_tab[k-1]) begin failed++; $display("FAIL wrap_hex[%0d]: got %h want %h", k, hex, win_tab[k-1]); end
        end
    endtask

    task automatic test_right;
        do_reset(4'b0111);
        cycles(4);
        tests++; if (pos !== 3'd7) begin failed++; $display("FAIL right_pos7: got %0d want 7", pos); end
        cycles(1);
        tests++; if (hex !== win_tab[7]) begin failed++; $display("FAIL right_hex7: got %h want %h", hex, win_tab[7]); end
        cycles(3);
        tests++; if (pos !== 3'd6) begin failed++; $display("FAIL right_pos6: got %0d want 6", pos); end
    endtask

    task automatic test_speed;
        do_reset(4'b1001);
        cycles(2);
        tests++; if (pos !== 3'd1) begin failed++; $display("FAIL speed2_pos1: got %0d want 1", pos); end
        cycles(2);
        tests++; if (pos !== 3'd2) begin failed++; $display("FAIL speed2_pos2: got %0d want 2", pos); end
        cycles(1);
        sw = 4'b0001;
        cycles(6);
        tests++; if (pos !== 3'd2) begin failed++; $display("FAIL speed0_early: got %0d want 2", pos); end
        cycles(1);
        tests++; if (pos !== 3'd3) begin failed++; $display("FAIL speed0_advance: got %0d want 3", pos); end
    endtask

    task automatic test_pause_step;
        do_reset(4'b0101);
        cycles(5);
        sw = 4'b0100;
        cycles(100);
        tests++; if (pos !== 3'd1) begin failed++; $display("FAIL pause_frozen: got %0d want 1", pos); end
        step_n = 1'b0;
        cycles(3);
        step_n = 1'b1;
        tests++; if (pos !== 3'd2) begin failed++; $display("FAIL step_pos: got %0d want 2", pos); end
        tests++; if (hex !== win_tab[1]) begin failed++; $display("FAIL step_hex_early: got %h want %h", hex, win_tab[1]); end
        cycles(1);
        tests++; if (hex !== win_tab[2]) begin failed++; $display("FAIL step_hex_latency: got %h want %h", hex, win_tab[2]); end
        cycles(10);
        tests++; if (pos !== 3'd2) begin failed++; $display("FAIL step_single: got %0d want 2", pos); end
        // cnt was held at 1, so the first tick after resuming is 3 cycles away
        sw = 4'b0101;
        cycles(2);
        tests++; if (pos !== 3'd2) begin failed++; $display("FAIL resume_early: got %0d want 2", pos); end
        cycles(1);
        tests++; if (pos !== 3'd3) begin failed++; $display("FAIL resume_held_cnt: got %0d want 3", pos); end
        step_n = 1'b0;
        cycles(3);
        step_n = 1'b1;
        tests++; if (pos !== 3'd3) begin failed++; $display("FAIL step_while_run: got %0d want 3", pos); end
        cycles(1);
        tests++; if (pos !== 3'd4) begin failed++; $display("FAIL run_tick_after_step: got %0d want 4", pos); end
        cycles(3);
        tests++; if (pos !== 3'd4) begin failed++; $display("FAIL run_no_extra: got %0d want 4", pos); end
    endtask

    task automatic test_reset_mid;
        do_reset(4'b0101);
        cycles(20);
        tests++; if (pos !== 3'd5) begin failed++; $display("FAIL mid_pos5: got %0d want 5", pos); end
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        tests++; if (pos !== 3'd0) begin failed++; $display("FAIL mid_reset_pos: got %0d want 0", pos); end
        tests++; if (hex !== 28'hFFFFFFF) begin failed++; $display("FAIL mid_reset_hex: got %h want %h", hex, 28'hFFFFFFF); end
        cycles(1);
        tests++; if (hex !== win_tab[0]) begin failed++; $display("FAIL mid_resume_hex: got %h want %h", hex, win_tab[0]); end
        cycles(3);
        tests++; if (pos !== 3'd1) begin failed++; $display("FAIL mid_resume_pos: got %0d want 1", pos); end
    endtask

    // Second instance advances every cycle, so its leftmost digit walks all codes
    task automatic test_glyphs;
        do_reset(4'b0101);
        cycles(1);
        for (int i = 0; i < 32; i++) begin
            tests++; if (hex_all[27:21] !== seg_tab[i]) begin failed++; $display("FAIL glyph[%0d]: got %h want %h", i, hex_all[27:21], seg_tab[i]); end
            cycles(1);
        end
    endtask

    initial begin
        win_tab[0] = {7'h40, 7'h21, 7'h06, 7'h79};
        win_tab[1] = {7'h21, 7'h06, 7'h79, 7'h7F};
        win_tab[2] = {7'h06, 7'h79, 7'h7F, 7'h7F};
        win_tab[3] = {7'h79, 7'h7F, 7'h7F, 7'h7F};
        win_tab[4] = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
        win_tab[5] = {7'h7F, 7'h7F, 7'h7F, 7'h40};
        win_tab[6] = {7'h7F, 7'h7F, 7'h40, 7'h21};
        win_tab[7] = {7'h7F, 7'h40, 7'h21, 7'h06};
        seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
        seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
        seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
        seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
        seg_tab[16] = 7'h7F; seg_tab[17] = 7'h3F;
        for (int i = 18; i < 32; i++) seg_tab[i] = 7'h7F;

        test_reset;
        test_wrap;
        test_right;
        test_speed;
        test_pause_step;
        test_reset_mid;
        test_glyphs;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
